// File: rtl/olink_pkg.sv
// Shared definitions for the optical link bring-up sequencer.
// Holds the state encoding (also exported on the status port) and the
// default timing/threshold values used as module parameter defaults.
package olink_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CPLL_RST  = 4'd1,
    ST_WAIT_CPLL = 4'd2,
    ST_TX_RST    = 4'd3,
    ST_WAIT_TX   = 4'd4,
    ST_RX_RST    = 4'd5,
    ST_WAIT_RX   = 4'd6,
    ST_CHECK     = 4'd7,
    ST_UP        = 4'd8,
    ST_FAIL      = 4'd9
  } state_e;

  localparam int unsigned DEF_PULSE_LEN    = 8;
  localparam int unsigned DEF_TIMEOUT      = 1250000;
  localparam int unsigned DEF_CHECK_CYCLES = 125000;
  localparam int unsigned DEF_MIN_COMMAS   = 16;
  localparam int unsigned DEF_LOSS_CYCLES  = 64;
  localparam int unsigned DEF_MAX_RETRY    = 4;

endpackage

// File: rtl/olink_sync_bit.sv
// Two-flop synchronizer for one asynchronous level into the clk domain.
// Ports: clk, rst (async active-high), d (async in), q (synced out).
module olink_sync_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/olink_bringup_seq.sv
// GTX channel bring-up/recovery sequencer (clk_125 domain).
// Pulses CPLL, TX and RX resets in order, waits for each lock/done,
// qualifies RX with a comma count over an error-free window, then holds
// link_up. Link loss re-runs the RX reset; lock loss re-runs everything;
// repeated failed attempts park in FAIL until restart or enable=0.
// Ports: clk_125/reset (async high); enable, restart controls; lock/done,
// rx_ok and comma_toggle async inputs; cpll_reset/tx_soft_reset/
// rx_soft_reset pulses; link_up, fail, state, retry_cnt, loss_cnt status.
module olink_bringup_seq
  import olink_pkg::*;
#(
  parameter int unsigned PULSE_LEN    = DEF_PULSE_LEN,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
  parameter int unsigned CHECK_CYCLES = DEF_CHECK_CYCLES,
  parameter int unsigned MIN_COMMAS   = DEF_MIN_COMMAS,
  parameter int unsigned LOSS_CYCLES  = DEF_LOSS_CYCLES,
  parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY
) (
  input  logic        clk_125,
  input  logic        reset,
  input  logic        enable,
  input  logic        restart,
  input  logic        cpll_lock,
  input  logic        tx_fsm_done,
  input  logic        rx_fsm_done,
  input  logic        rx_reset_done,
  input  logic        clk_link_lock,
  input  logic        rx_ok,
  input  logic        comma_toggle,
  output logic        cpll_reset,
  output logic        tx_soft_reset,
  output logic        rx_soft_reset,
  output logic        link_up,
  output logic        fail,
  output logic [3:0]  state,
  output logic [7:0]  retry_cnt,
  output logic [15:0] loss_cnt
);

  // One timer serves pulse width, wait timeout and qualification window.
  localparam int unsigned TMR_MAX = (TIMEOUT > CHECK_CYCLES) ?
      ((TIMEOUT > PULSE_LEN) ? TIMEOUT : PULSE_LEN) :
      ((CHECK_CYCLES > PULSE_LEN) ? CHECK_CYCLES : PULSE_LEN);
  localparam int unsigned TMR_W = $clog2(TMR_MAX + 1);
  localparam int unsigned CMA_W = $clog2(MIN_COMMAS + 1);
  localparam int unsigned LOS_W = $clog2(LOSS_CYCLES + 1);

  // Synchronize every async input.
  logic [6:0] async_in;
  logic [6:0] sync_s;
  assign async_in = {comma_toggle, rx_ok, clk_link_lock, rx_reset_done,
                     rx_fsm_done, tx_fsm_done, cpll_lock};

  for (genvar i = 0; i < 7; i++) begin : g_sync
    olink_sync_bit u_sync (
      .clk (clk_125),
      .rst (reset),
      .d   (async_in[i]),
      .q   (sync_s[i])
    );
  end

  logic locks_ok;
  logic tx_done_s;
  logic rx_done_s;
  logic rx_ok_s;
  logic comma_s;
  assign locks_ok  = sync_s[0] & sync_s[4];
  assign tx_done_s = sync_s[1];
  assign rx_done_s = sync_s[2] & sync_s[3];
  assign rx_ok_s   = sync_s[5];
  assign comma_s   = sync_s[6];

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CMA_W-1:0]   cma_q, cma_d;
  logic [LOS_W-1:0]   los_q, los_d;
  logic [7:0]         retry_q, retry_d;
  logic [15:0]        loss_q, loss_d;
  logic               comma_prev_q, comma_prev_d;
  logic               cpll_rst_q, cpll_rst_d;
  logic               tx_rst_q, tx_rst_d;
  logic               rx_rst_q, rx_rst_d;
  logic               link_up_q, link_up_d;
  logic               fail_q, fail_d;

  logic               attempt_fail;
  logic               restart_hit;
  logic               timeout_hit;
  logic [7:0]         retry_inc;
  logic [15:0]        loss_inc;
  logic [CMA_W-1:0]   cma_inc;
  logic [LOS_W-1:0]   los_inc;
  logic [TMR_W-1:0]   tmr_inc;

  // Next-state, counters and registered outputs.
  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    loss_d       = loss_q;
    cma_d        = cma_q;
    los_d        = '0;
    comma_prev_d = comma_s;
    attempt_fail = 1'b0;
    restart_hit  = 1'b0;

    tmr_inc   = (32'(timer_q) >= TMR_MAX) ? timer_q : timer_q + TMR_W'(1);
    retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
    loss_inc  = (loss_q == 16'hFFFF) ? loss_q : loss_q + 16'd1;
    cma_inc   = ((comma_s ^ comma_prev_q) && (32'(cma_q) < MIN_COMMAS)) ?
                cma_q + CMA_W'(1) : cma_q;
    los_inc   = (32'(los_q) >= LOSS_CYCLES) ? los_q : los_q + LOS_W'(1);
    timeout_hit = (32'(timer_q) == TIMEOUT - 1);

    case (state_q)
      ST_IDLE:      if (enable) state_d = ST_CPLL_RST;
      ST_CPLL_RST:  if (32'(timer_q) == PULSE_LEN - 1) state_d = ST_WAIT_CPLL;
      ST_WAIT_CPLL: begin
        if (locks_ok)         state_d = ST_TX_RST;
        else if (timeout_hit) attempt_fail = 1'b1;
      end
      ST_TX_RST:    if (32'(timer_q) == PULSE_LEN - 1) state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (!locks_ok || (!tx_done_s && timeout_hit)) attempt_fail = 1'b1;
        else if (tx_done_s)                           state_d = ST_RX_RST;
      end
      ST_RX_RST:    if (32'(timer_q) == PULSE_LEN - 1) state_d = ST_WAIT_RX;
      ST_WAIT_RX: begin
        if (!locks_ok || (!rx_done_s && timeout_hit)) attempt_fail = 1'b1;
        else if (rx_done_s)                           state_d = ST_CHECK;
      end
      ST_CHECK: begin
        cma_d = cma_inc;
        if (!locks_ok || !rx_ok_s) begin
          attempt_fail = 1'b1;
        end else if (32'(timer_q) == CHECK_CYCLES - 1) begin
          if (32'(cma_inc) >= MIN_COMMAS) state_d = ST_UP;
          else                            attempt_fail = 1'b1;
        end
      end
      ST_UP: begin
        los_d = rx_ok_s ? '0 : los_inc;
        if (!locks_ok) begin
          loss_d  = loss_inc;
          state_d = ST_CPLL_RST;
        end else if (!rx_ok_s && (32'(los_inc) == LOSS_CYCLES)) begin
          loss_d  = loss_inc;
          state_d = ST_RX_RST;
        end
      end
      ST_FAIL:      state_d = ST_FAIL;
      default:      state_d = ST_IDLE;
    endcase

    if (attempt_fail) begin
      retry_d = retry_inc;
      state_d = (32'(retry_inc) >= MAX_RETRY) ? ST_FAIL : ST_CPLL_RST;
    end
    if ((state_d == ST_UP) && (state_q != ST_UP)) retry_d = '0;

    // Overrides: enable low beats restart, restart beats normal flow.
    if (!enable) begin
      state_d = ST_IDLE;
      retry_d = '0;
      loss_d  = loss_q;
    end else if (restart && (state_q != ST_IDLE)) begin
      state_d     = ST_CPLL_RST;
      retry_d     = '0;
      loss_d      = loss_q;
      restart_hit = 1'b1;
    end

    if (state_d != ST_CHECK) cma_d = '0;
    if (state_d != ST_UP)    los_d = '0;
    timer_d = ((state_d != state_q) || restart_hit) ? '0 : tmr_inc;

    cpll_rst_d = (state_d == ST_CPLL_RST);
    tx_rst_d   = (state_d == ST_TX_RST);
    rx_rst_d   = (state_d == ST_RX_RST);
    link_up_d  = (state_d == ST_UP);
    fail_d     = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk_125 or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      cma_q        <= '0;
      los_q        <= '0;
      retry_q      <= '0;
      loss_q       <= '0;
      comma_prev_q <= 1'b0;
      cpll_rst_q   <= 1'b0;
      tx_rst_q     <= 1'b0;
      rx_rst_q     <= 1'b0;
      link_up_q    <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      cma_q        <= cma_d;
      los_q        <= los_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      comma_prev_q <= comma_prev_d;
      cpll_rst_q   <= cpll_rst_d;
      tx_rst_q     <= tx_rst_d;
      rx_rst_q     <= rx_rst_d;
      link_up_q    <= link_up_d;
      fail_q       <= fail_d;
    end
  end

  assign cpll_reset    = cpll_rst_q;
  assign tx_soft_reset = tx_rst_q;
  assign rx_soft_reset = rx_rst_q;
  assign link_up       = link_up_q;
  assign fail          = fail_q;
  assign state         = state_q;
  assign retry_cnt     = retry_q;
  assign loss_cnt      = loss_q;

endmodule

// File: tb/tb_olink_bringup_seq.sv
// Self-checking bench for olink_bringup_seq. A behavioural GTX model
// answers the reset pulses with randomized lock delays; scenario code
// pushes the expected sequence of visited states (with counters and the
// time spent in the previous state) and a monitor compares each state
// change the DUT presents against the queue.
module tb_olink_bringup_seq;

  localparam int unsigned P_PULSE = 4;
  localparam int unsigned P_TO    = 100;
  localparam int unsigned P_CHECK = 200;
  localparam int unsigned P_MINC  = 16;
  localparam int unsigned P_LOSS  = 64;
  localparam int unsigned P_RETRY = 2;

  logic        clk_125 = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        restart = 1'b0;
  logic        cpll_lock = 1'b0;
  logic        tx_fsm_done = 1'b0;
  logic        rx_fsm_done = 1'b0;
  logic        rx_reset_done = 1'b0;
  logic        clk_link_lock = 1'b0;
  logic        rx_ok = 1'b1;
  logic        comma_toggle = 1'b0;
  logic        cpll_reset, tx_soft_reset, rx_soft_reset, link_up, fail;
  logic [3:0]  state;
  logic [7:0]  retry_cnt;
  logic [15:0] loss_cnt;

  olink_bringup_seq #(
    .PULSE_LEN    (P_PULSE),
    .TIMEOUT      (P_TO),
    .CHECK_CYCLES (P_CHECK),
    .MIN_COMMAS   (P_MINC),
    .LOSS_CYCLES  (P_LOSS),
    .MAX_RETRY    (P_RETRY)
  ) dut (
    .clk_125       (clk_125),
    .reset         (reset),
    .enable        (enable),
    .restart       (restart),
    .cpll_lock     (cpll_lock),
    .tx_fsm_done   (tx_fsm_done),
    .rx_fsm_done   (rx_fsm_done),
    .rx_reset_done (rx_reset_done),
    .clk_link_lock (clk_link_lock),
    .rx_ok         (rx_ok),
    .comma_toggle  (comma_toggle),
    .cpll_reset    (cpll_reset),
    .tx_soft_reset (tx_soft_reset),
    .rx_soft_reset (rx_soft_reset),
    .link_up       (link_up),
    .fail          (fail),
    .state         (state),
    .retry_cnt     (retry_cnt),
    .loss_cnt      (loss_cnt)
  );

  always #5 clk_125 = ~clk_125;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Expected state-change record; dwell < 0 means "not checked".
  typedef struct {
    logic [3:0]  st;
    int          dwell;
    logic [7:0]  retry;
    logic [15:0] loss;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  m_retry = 8'd0;
  logic [15:0] m_loss = 16'd0;

  task automatic expect_st(input logic [3:0] st, input int dwell);
    exp_t e;
    e.st = st; e.dwell = dwell; e.retry = m_retry; e.loss = m_loss;
    exp_q.push_back(e);
  endtask

  // Full bring-up from CPLL reset to UP; entering UP clears the retry count.
  task automatic expect_path_to_up(input int first_dwell);
    expect_st(4'd1, first_dwell);
    expect_st(4'd2, P_PULSE);
    expect_st(4'd3, -1);
    expect_st(4'd4, P_PULSE);
    expect_st(4'd5, -1);
    expect_st(4'd6, P_PULSE);
    expect_st(4'd7, -1);
    m_retry = 8'd0;
    expect_st(4'd8, P_CHECK);
  endtask

  // ---------------- monitor ----------------
  bit         mon_en = 1'b0;
  logic [3:0] prev_st = 4'd0;
  int         dwell = 0;
  exp_t       mon_e;

  always @(negedge clk_125) begin
    if (mon_en) begin
      if (state != prev_st) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change: got state %0d from %0d, expected no change (t=%0t)",
                   state, prev_st, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("st_state", 32'(state), 32'(mon_e.st));
          if (mon_e.dwell >= 0) check("st_dwell", 32'(dwell), 32'(mon_e.dwell));
          check("st_retry", 32'(retry_cnt), 32'(mon_e.retry));
          check("st_loss", 32'(loss_cnt), 32'(mon_e.loss));
          check("st_link_up", 32'(link_up), 32'(mon_e.st == 4'd8));
          check("st_fail", 32'(fail), 32'(mon_e.st == 4'd9));
          check("st_cpll_reset", 32'(cpll_reset), 32'(mon_e.st == 4'd1));
          check("st_tx_reset", 32'(tx_soft_reset), 32'(mon_e.st == 4'd3));
          check("st_rx_reset", 32'(rx_soft_reset), 32'(mon_e.st == 4'd5));
        end
        prev_st = state;
        dwell = 1;
      end else begin
        dwell++;
      end
    end
  end

  // ---------------- GTX / link environment ----------------
  int cpll_dly = 10, tx_dly = 10, rx_dly = 10;
  int cpll_c = 0, tx_c = 0, rx_c = 0;
  bit cpll_block = 1'b0;
  bit link_kill = 1'b0;
  int comma_per = 8;
  int comma_c = 0;
  int cpll_pulses = 0, tx_pulses = 0;
  logic cpll_prev = 1'b0, tx_prev = 1'b0;

  always @(negedge clk_125) begin
    if (cpll_reset || cpll_block) begin
      cpll_c = 0; cpll_lock = 1'b0;
    end else if (cpll_c < cpll_dly) cpll_c++;
    else cpll_lock = 1'b1;
    clk_link_lock = cpll_lock && !link_kill;

    if (tx_soft_reset) begin
      tx_c = 0; tx_fsm_done = 1'b0;
    end else if (tx_c < tx_dly) tx_c++;
    else tx_fsm_done = 1'b1;

    if (rx_soft_reset) begin
      rx_c = 0; rx_fsm_done = 1'b0;
    end else if (rx_c < rx_dly) rx_c++;
    else rx_fsm_done = 1'b1;
    rx_reset_done = rx_fsm_done;

    if (comma_per != 0) begin
      comma_c++;
      if (comma_c >= comma_per) begin
        comma_c = 0;
        comma_toggle = ~comma_toggle;
      end
    end

    if (cpll_reset && !cpll_prev) cpll_pulses++;
    if (tx_soft_reset && !tx_prev) tx_pulses++;
    cpll_prev = cpll_reset;
    tx_prev   = tx_soft_reset;
  end

  task automatic rand_env();
    cpll_dly = $urandom_range(5, 40);
    tx_dly   = $urandom_range(5, 40);
    rx_dly   = $urandom_range(5, 40);
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk_125);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending states (state %0d), expected 0", name,
               exp_q.size(), state);
      exp_q.delete();
    end
    @(negedge clk_125);
  endtask

  task automatic pulse_restart();
    @(negedge clk_125);
    restart = 1'b1;
    @(negedge clk_125);
    restart = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int cp_snap;
    int tx_snap;

    rand_env();
    repeat (4) @(negedge clk_125);
    check("rst_state", 32'(state), 32'd0);
    check("rst_link_up", 32'(link_up), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_cpll", 32'(cpll_reset), 32'd0);
    check("rst_tx", 32'(tx_soft_reset), 32'd0);
    check("rst_rx", 32'(rx_soft_reset), 32'd0);
    check("rst_retry", 32'(retry_cnt), 32'd0);
    check("rst_loss", 32'(loss_cnt), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk_125);
    check("idle_hold", 32'(state), 32'd0);
    mon_en = 1'b1;

    // Nominal bring-up.
    expect_path_to_up(-1);
    enable = 1'b1;
    wait_empty("nominal", 3000);
    check("nom_link_up", 32'(link_up), 32'd1);
    check("nom_state", 32'(state), 32'd8);
    check("nom_retry", 32'(retry_cnt), 32'd0);

    // Random short rx_ok dips never drop the link.
    repeat (3) begin
      len = $urandom_range(1, 62);
      rx_ok = 1'b0;
      repeat (len) @(negedge clk_125);
      rx_ok = 1'b1;
      repeat (10) @(negedge clk_125);
      check("dip_stay_up", 32'(state), 32'd8);
    end

    // Boundary: 63 low cycles stays up, 64 triggers RX-only recovery.
    rx_ok = 1'b0;
    repeat (P_LOSS - 1) @(negedge clk_125);
    rx_ok = 1'b1;
    repeat (20) @(negedge clk_125);
    check("loss63_state", 32'(state), 32'd8);
    check("loss63_cnt", 32'(loss_cnt), 32'(m_loss));
    rand_env();
    cp_snap = cpll_pulses;
    tx_snap = tx_pulses;
    m_loss = m_loss + 16'd1;
    expect_st(4'd5, -1);
    expect_st(4'd6, P_PULSE);
    expect_st(4'd7, -1);
    expect_st(4'd8, P_CHECK);
    rx_ok = 1'b0;
    repeat (P_LOSS) @(negedge clk_125);
    rx_ok = 1'b1;
    wait_empty("loss64", 3000);
    check("loss64_cnt", 32'(loss_cnt), 32'd1);
    check("loss64_no_cpll", 32'(cpll_pulses), 32'(cp_snap));
    check("loss64_no_tx", 32'(tx_pulses), 32'(tx_snap));

    // Weak comma rate fails qualification once, then recovers.
    rand_env();
    comma_per = 25;
    expect_st(4'd1, -1);
    expect_st(4'd2, P_PULSE);
    expect_st(4'd3, -1);
    expect_st(4'd4, P_PULSE);
    expect_st(4'd5, -1);
    expect_st(4'd6, P_PULSE);
    expect_st(4'd7, -1);
    m_retry = 8'd1;
    expect_st(4'd1, P_CHECK);
    pulse_restart();
    wait_empty("weak_comma", 3000);
    check("weak_retry", 32'(retry_cnt), 32'd1);
    comma_per = 8;
    expect_st(4'd2, P_PULSE);
    expect_st(4'd3, -1);
    expect_st(4'd4, P_PULSE);
    expect_st(4'd5, -1);
    expect_st(4'd6, P_PULSE);
    expect_st(4'd7, -1);
    m_retry = 8'd0;
    expect_st(4'd8, P_CHECK);
    wait_empty("weak_recover", 3000);

    // Lock loss in UP counts a loss and re-runs the full sequence.
    rand_env();
    m_loss = m_loss + 16'd1;
    expect_path_to_up(-1);
    link_kill = 1'b1;
    repeat (3) @(negedge clk_125);
    link_kill = 1'b0;
    wait_empty("lock_loss", 3000);
    check("lock_loss_cnt", 32'(loss_cnt), 32'(m_loss));

    // CPLL never locks: two timed-out attempts then FAIL.
    expect_st(4'd1, -1);
    expect_st(4'd2, P_PULSE);
    m_retry = 8'd1;
    expect_st(4'd1, P_TO);
    expect_st(4'd2, P_PULSE);
    m_retry = 8'd2;
    expect_st(4'd9, P_TO);
    cpll_block = 1'b1;
    pulse_restart();
    wait_empty("timeout", 3000);
    repeat (30) @(negedge clk_125);
    check("to_fail", 32'(fail), 32'd1);
    check("to_state", 32'(state), 32'd9);
    check("to_retry", 32'(retry_cnt), 32'd2);
    check("to_link_up", 32'(link_up), 32'd0);
    cpll_block = 1'b0;
    rand_env();
    m_retry = 8'd0;
    expect_path_to_up(-1);
    pulse_restart();
    wait_empty("fail_restart", 3000);

    // enable dropped in the middle of the TX reset pulse.
    expect_st(4'd1, -1);
    expect_st(4'd2, P_PULSE);
    expect_st(4'd3, -1);
    pulse_restart();
    wait_empty("to_tx_rst", 3000);
    expect_st(4'd0, -1);
    enable = 1'b0;
    @(posedge clk_125);
    #1;
    check("en_drop_tx", 32'(tx_soft_reset), 32'd0);
    check("en_drop_state", 32'(state), 32'd0);
    wait_empty("en_drop", 100);
    repeat (5) @(negedge clk_125);
    rand_env();
    expect_path_to_up(-1);
    enable = 1'b1;
    wait_empty("re_enable", 3000);

    // Async reset while qualifying.
    expect_st(4'd1, -1);
    expect_st(4'd2, P_PULSE);
    expect_st(4'd3, -1);
    expect_st(4'd4, P_PULSE);
    expect_st(4'd5, -1);
    expect_st(4'd6, P_PULSE);
    expect_st(4'd7, -1);
    pulse_restart();
    wait_empty("to_check", 3000);
    repeat (20) @(negedge clk_125);
    m_retry = 8'd0;
    m_loss = 16'd0;
    expect_st(4'd0, -1);
    #1;
    reset = 1'b1;
    #1;
    check("areset_state", 32'(state), 32'd0);
    check("areset_link_up", 32'(link_up), 32'd0);
    check("areset_fail", 32'(fail), 32'd0);
    check("areset_resets", 32'({cpll_reset, tx_soft_reset, rx_soft_reset}), 32'd0);
    check("areset_loss", 32'(loss_cnt), 32'd0);
    check("areset_retry", 32'(retry_cnt), 32'd0);
    repeat (3) @(negedge clk_125);
    expect_path_to_up(-1);
    reset = 1'b0;
    wait_empty("after_areset", 3000);
    check("final_link_up", 32'(link_up), 32'd1);

    repeat (50) @(negedge clk_125);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
